// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter.
// Direction and mode encodings plus the next-count select used by the top.
package counter_pkg;

    localparam logic CNT_DOWN = 1'b0;
    localparam logic CNT_UP   = 1'b1;

    localparam logic CNT_WRAP = 1'b0;
    localparam logic CNT_SAT  = 1'b1;

    // Source of the next count value.
    //   HOLD    : keep current count
    //   LOAD    : take load_val
    //   INC/DEC : +1 / -1
    //   WRAP_LO : go to 0 (up-boundary in wrap mode)
    //   WRAP_HI : go to modulo_max (down-boundary wrap, or clamp of an over-range count)
    //   SAT     : pin at the boundary of the current direction (modulo_max up, 0 down)
    typedef enum logic [2:0] {
        HOLD,
        LOAD,
        INC,
        DEC,
        WRAP_LO,
        WRAP_HI,
        SAT
    } cnt_sel_e;

endpackage

// File: rtl/counter_prescaler.sv
// Step prescaler for counter_updown_mod: qualifies every (div+1)-th enabled
// cycle. Only instantiated when COUNTER_PRESCALE_EN is defined.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div,
    output logic             step
);

    logic [WIDTH-1:0] cnt_reg;

    // >= rather than == so a div lowered below the current phase fires at once
    assign step = enable && !load && (cnt_reg >= div);

    // Phase counter: restarts on load, freezes while enable is low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= '0;
        end else if (enable) begin
            cnt_reg <= step ? '0 : cnt_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with programmable terminal value, synchronous
// load, wrap/saturate mode, registered terminal-count pulse and sticky
// overflow/underflow flags.
// Optional macro COUNTER_PRESCALE_EN adds a step prescaler (prescale_div).
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef COUNTER_PRESCALE_EN
    ,
    parameter int               PRESCALE_W = 8
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] modulo_max,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             flag_clr,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_div,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] count_reg, count_next;
    logic             tc_reg;
    logic             overflow_reg, underflow_reg;
    logic             step_qual;
    logic             up_evt, dn_evt;
    cnt_sel_e         sel;

`ifdef COUNTER_PRESCALE_EN
    counter_prescaler #(
        .WIDTH (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .load    (load),
        .div     (prescale_div),
        .step    (step_qual)
    );
`else
    assign step_qual = enable;
`endif

    // Choose the next-count source and detect boundary events
    always_comb begin
        sel    = HOLD;
        up_evt = 1'b0;
        dn_evt = 1'b0;
        if (load) begin
            sel = LOAD;
        end else if (step_qual) begin
            if (up_dn == CNT_UP) begin
                // >= so an over-range count (after load or a shrunk modulo) still wraps/pins
                if (count_reg >= modulo_max) begin
                    up_evt = 1'b1;
                    sel    = (sat_mode == CNT_SAT) ? SAT : WRAP_LO;
                end else begin
                    sel = INC;
                end
            end else begin
                if (count_reg > modulo_max) begin
                    sel = WRAP_HI;  // clamp back into range, not a boundary event
                end else if (count_reg == '0) begin
                    dn_evt = 1'b1;
                    sel    = (sat_mode == CNT_SAT) ? SAT : WRAP_HI;
                end else begin
                    sel = DEC;
                end
            end
        end
    end

    // Map the select onto the next count value
    always_comb begin
        count_next = count_reg;
        case (sel)
            HOLD:    count_next = count_reg;
            LOAD:    count_next = load_val;
            INC:     count_next = count_reg + WIDTH'(1);
            DEC:     count_next = count_reg - WIDTH'(1);
            WRAP_LO: count_next = '0;
            WRAP_HI: count_next = modulo_max;
            SAT:     count_next = (up_dn == CNT_UP) ? modulo_max : '0;
            default: count_next = count_reg;
        endcase
    end

    // Count, terminal pulse and sticky flags; a same-cycle event beats flag_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg     <= RESET_VAL;
            tc_reg        <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            tc_reg        <= up_evt | dn_evt;
            overflow_reg  <= up_evt | (overflow_reg & ~flag_clr);
            underflow_reg <= dn_evt | (underflow_reg & ~flag_clr);
        end
    end

    assign count     = count_reg;
    assign tc        = tc_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised up/down counter with programmable terminal value (modulo), synchronous load, and wrap or saturate mode.
- Registered terminal-count pulse plus sticky overflow/underflow flags with software clear.
- Successor to the fixed 32-bit up-only wrap counter.
- Used as a general event/timer counter in control and status blocks.

Parameters:
- WIDTH, 32, counter width in bits (>= 2).
- RESET_VAL, 0, value loaded into count on reset; must be <= 2^WIDTH-1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  count-step enable, active high.
- up_dn  in  1  direction: 1 = up, 0 = down.
- sat_mode  in  1  1 = saturate at boundary, 0 = wrap.
- modulo_max  in  WIDTH  terminal value; counting range is 0..modulo_max.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value taken on load.
- flag_clr  in  1  clears the sticky flags.
- count  out  WIDTH  current count, registered.
- tc  out  1  one-cycle terminal-count pulse, registered.
- overflow  out  1  sticky: an up-boundary event occurred.
- underflow  out  1  sticky: a down-boundary event occurred.

Behaviour:
- Reset (reset_n low, asynchronous):
  - count = RESET_VAL; tc = 0; overflow = 0; underflow = 0.
  - Deassertion is synchronised externally; the first active edge after release evaluates normally.
- Per-edge priority: load > enable step > hold.
- Load:
  - count <= load_val, including values > modulo_max.
  - tc = 0 that cycle; flags unaffected.
- Up step (enable=1, up_dn=1):
  - count < modulo_max: count+1, tc=0.
  - count >= modulo_max (up-boundary event):
    - wrap: count <= 0.
    - saturate: count <= modulo_max.
    - tc=1 next cycle; overflow set.
- Down step (enable=1, up_dn=0):
  - count > modulo_max: count <= modulo_max (clamp). Not a boundary event; tc=0.
  - 0 < count <= modulo_max: count-1, tc=0.
  - count == 0 (down-boundary event):
    - wrap: count <= modulo_max.
    - saturate: count stays 0.
    - tc=1 next cycle; underflow set.
- Saturate mode: repeated steps at the boundary produce tc every enabled cycle and keep the flag set.
- Hold (enable=0, load=0): count unchanged; tc=0.
- modulo_max == 0: up step gives count 0 and tc every step; down step at 0 behaves the same for underflow.
- modulo_max changed mid-count: takes effect on the next step, using the comparisons above (>= for up, clamp for down).
- flag_clr:
  - Clears overflow and underflow on the next edge.
  - If a boundary event occurs in the same cycle, set wins for that flag.
- Arithmetic is WIDTH-bit unsigned. No intermediate carry is exposed. modulo_max = 2^WIDTH-1 gives natural full-range wrap.
- Latency: count and tc update one cycle after the qualifying inputs; no combinational input-to-output paths.

Optional Feature:
- Macro COUNTER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE_W (default 8) and input prescale_div[PRESCALE_W].
  - A step occurs only on every (prescale_div+1)-th enabled cycle.
  - The prescaler counter resets to 0 on reset_n and on load, and holds while enable=0.
  - prescale_div=0 is identical to no prescaler.
- Undefined: port and parameter absent; every enabled cycle is a step.

Decomposition:
- Shared package counter_pkg:
  - Direction constants CNT_DOWN=1'b0, CNT_UP=1'b1.
  - Mode constants CNT_WRAP=1'b0, CNT_SAT=1'b1.
  - Typedef for the next-state select: HOLD, LOAD, INC, DEC, WRAP_LO, WRAP_HI, SAT.
- One sub-module, counter_prescaler: emits a step-qualify pulse; instantiated only under COUNTER_PRESCALE_EN.

Test Plan (WIDTH=8):
- Reset mid-count: at count=0x37, pull reset_n low between edges -> count=0x00 immediately, tc/overflow/underflow=0; after release with enable=1, up -> count 1,2,3.
- Up wrap: modulo_max=9, sat_mode=0, enable=1 from 0 -> sequence 0..9,0; tc high exactly the cycle count shows 0; overflow=1 and stays 1.
- Down saturate: modulo_max=5, sat_mode=1, load_val=2 then down -> count 2,1,0,0,0; tc high on each 0 after the first; underflow=1.
- Load above modulo: modulo_max=10, load 200 -> up step gives count 0 with tc and overflow; reload 200 then down step gives count 10, no tc.
- Clear vs event: overflow=1, flag_clr=1 same cycle as up-boundary event -> overflow stays 1; next cycle flag_clr alone -> overflow=0.
- Load vs enable (and prescale with COUNTER_PRESCALE_EN, prescale_div=2): load=1 with enable=1 -> count=load_val; then enable held -> count increments every 3rd cycle.
